// File: rtl/vga_timing_generator_if.sv
// Raster bus between the VGA timing generator and the pixel generation stage.
// The generator owns the coordinates, syncs and colour output; pixel logic returns pixelIn.
interface vga_timing_generator_if;
    logic        pixelEn;
    logic [7:0]  pixelIn;
    logic [15:0] nextX;
    logic [15:0] nextY;
    logic        nextVisible;
    logic        hsync;
    logic        vsync;
    logic [7:0]  rgbOut;
    logic        frameTick;

    modport master (
        input  pixelEn,
        input  pixelIn,
        output nextX,
        output nextY,
        output nextVisible,
        output hsync,
        output vsync,
        output rgbOut,
        output frameTick
    );

    modport slave (
        output pixelEn,
        output pixelIn,
        input  nextX,
        input  nextY,
        input  nextVisible,
        input  hsync,
        input  vsync,
        input  rgbOut,
        input  frameTick
    );
endinterface

// File: rtl/vga_timing_generator.sv
// VGA raster timing: h/v counters, registered syncs and blank-gated pixel, frame tick.
// Outputs lag the coordinate by one enabled edge; with pixelEn low everything holds.
module vga_timing_generator #(
    parameter int   H_ACTIVE          = 640,
    parameter int   H_FRONT           = 16,
    parameter int   H_SYNC            = 96,
    parameter int   H_BACK            = 48,
    parameter int   V_ACTIVE          = 480,
    parameter int   V_FRONT           = 10,
    parameter int   V_SYNC            = 2,
    parameter int   V_BACK            = 33,
    parameter logic SYNC_ACTIVE_LEVEL = 1'b0
) (
    input logic                    clk,
    input logic                    resetN,
    vga_timing_generator_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [15:0] H_FRONT_START = 16'(H_ACTIVE);
    localparam logic [15:0] H_SYNC_START  = 16'(H_ACTIVE + H_FRONT);
    localparam logic [15:0] H_BACK_START  = 16'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [15:0] H_LAST        = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_FRONT_START = 16'(V_ACTIVE);
    localparam logic [15:0] V_SYNC_START  = 16'(V_ACTIVE + V_FRONT);
    localparam logic [15:0] V_BACK_START  = 16'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [15:0] V_LAST        = 16'(V_TOTAL - 1);
    localparam logic [15:0] V_ACT_LAST    = 16'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_e;

    logic [15:0] h_count_q, h_count_d;
    logic [15:0] v_count_q, v_count_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [7:0]  rgb_q, rgb_d;
    logic        frame_tick_q, frame_tick_d;

    phase_e h_phase;
    phase_e v_phase;
    logic   visible;
    logic   h_last;
    logic   v_last;

    always_comb begin
        h_phase = PH_BACK;
        if (h_count_q < H_FRONT_START) begin
            h_phase = PH_ACTIVE;
        end else if (h_count_q < H_SYNC_START) begin
            h_phase = PH_FRONT;
        end else if (h_count_q < H_BACK_START) begin
            h_phase = PH_SYNC;
        end

        v_phase = PH_BACK;
        if (v_count_q < V_FRONT_START) begin
            v_phase = PH_ACTIVE;
        end else if (v_count_q < V_SYNC_START) begin
            v_phase = PH_FRONT;
        end else if (v_count_q < V_BACK_START) begin
            v_phase = PH_SYNC;
        end
    end

    assign visible = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    // >= rather than == so a corrupted count still wraps instead of running away
    assign h_last  = (h_count_q >= H_LAST);
    assign v_last  = (v_count_q >= V_LAST);

    always_comb begin
        h_count_d    = h_count_q;
        v_count_d    = v_count_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        rgb_d        = rgb_q;
        frame_tick_d = 1'b0;
        if (vga.pixelEn) begin
            if (h_last) begin
                h_count_d = 16'd0;
                v_count_d = v_last ? 16'd0 : v_count_q + 16'd1;
            end else begin
                h_count_d = h_count_q + 16'd1;
            end
            rgb_d        = visible ? vga.pixelIn : 8'h00;
            hsync_d      = (h_phase == PH_SYNC) ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
            vsync_d      = (v_phase == PH_SYNC) ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
            frame_tick_d = h_last && (v_count_q == V_ACT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            h_count_q    <= 16'd0;
            v_count_q    <= 16'd0;
            hsync_q      <= ~SYNC_ACTIVE_LEVEL;
            vsync_q      <= ~SYNC_ACTIVE_LEVEL;
            rgb_q        <= 8'h00;
            frame_tick_q <= 1'b0;
        end else begin
            h_count_q    <= h_count_d;
            v_count_q    <= v_count_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            rgb_q        <= rgb_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign vga.nextX       = h_count_q;
    assign vga.nextY       = v_count_q;
    assign vga.nextVisible = visible;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.rgbOut      = rgb_q;
    assign vga.frameTick   = frame_tick_q;

endmodule
